// File: rtl/wb_regfile.sv
// Writeback-stage register file: result select, 32x32 GPR array, decode read ports,
// debug port and retired-write counter. Define WB_REGFILE_BYPASS_EN for same-cycle W->D bypass.
module wb_regfile #(
   parameter int unsigned DW = 32,
   parameter int unsigned AW = 5
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          RFWEW,
   input  logic          MtoRFSelW,
   input  logic [DW-1:0] ALUOutW,
   input  logic [DW-1:0] DMOutW,
   input  logic [AW-1:0] rtdW,
   input  logic [AW-1:0] rsD,
   input  logic [AW-1:0] rtD,
   output logic [DW-1:0] RFRD1,
   output logic [DW-1:0] RFRD2,
   output logic [DW-1:0] ResultW,
   input  logic [AW-1:0] dbgAddr,
   output logic [DW-1:0] dbgData,
   output logic [31:0]   RetireCnt
);

   localparam int unsigned NREG = 1 << AW;
   localparam int unsigned CW   = 32;

   logic [DW-1:0] r_regs [NREG];
   logic [CW-1:0] r_retire_cnt;

   logic          w_commit;
   logic          w_byp1;
   logic          w_byp2;
   logic [DW-1:0] w_arr1;
   logic [DW-1:0] w_arr2;

   assign ResultW  = MtoRFSelW ? DMOutW : ALUOutW;
   assign w_commit = RFWEW && (rtdW != '0);

   // Register 0 is never written; reads of it are forced to zero as well.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < NREG; i++) begin
            r_regs[i] <= '0;
         end
      end else if (w_commit) begin
         r_regs[rtdW] <= ResultW;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_retire_cnt <= '0;
      end else if (w_commit) begin
         r_retire_cnt <= r_retire_cnt + CW'(1);
      end
   end

   assign w_arr1  = (rsD == '0)     ? '0 : r_regs[rsD];
   assign w_arr2  = (rtD == '0)     ? '0 : r_regs[rtD];
   assign dbgData = (dbgAddr == '0) ? '0 : r_regs[dbgAddr];

`ifdef WB_REGFILE_BYPASS_EN
   // Suppressed during reset so the decode ports still read zero.
   assign w_byp1 = rst_n && w_commit && (rsD == rtdW);
   assign w_byp2 = rst_n && w_commit && (rtD == rtdW);
`else
   assign w_byp1 = 1'b0;
   assign w_byp2 = 1'b0;
`endif

   assign RFRD1     = w_byp1 ? ResultW : w_arr1;
   assign RFRD2     = w_byp2 ? ResultW : w_arr2;
   assign RetireCnt = r_retire_cnt;

endmodule
